// File: rtl/banked_ram.sv
// banked_ram: single-port RAM split into 2^BANK_BITS independent banks.
// The bank is chosen by the address MSBs and the word by the remaining
// offset bits. After reset, an init sweep writes INIT_VAL to every offset
// in all banks in parallel. The sweep takes DEPTH cycles. Requests are
// accepted only once the sweep has finished. Reads return registered data
// one cycle after acceptance, together with a one-cycle rsp_valid pulse.
//
// Ports:
//   clk        clock, every register updates on posedge
//   rst        synchronous active-high reset; restarts the init sweep
//   req_valid  request present
//   req_ready  block accepts requests (low during the init sweep)
//   req_we     1 = write, 0 = read
//   req_addr   word address: {bank, offset}
//   req_wdata  write data
//   rsp_valid  one-cycle pulse, rsp_rdata carries read data
//   rsp_rdata  registered read data, holds its value between responses
//   init_busy  init sweep in progress
module banked_ram #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 10,
  parameter int                BANK_BITS = 2,
  parameter logic [DATA_W-1:0] INIT_VAL  = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_busy
);

  localparam int OFF_W = ADDR_W - BANK_BITS;
  localparam int NBANK = 1 << BANK_BITS;
  localparam int DEPTH = 1 << OFF_W;
  localparam logic [OFF_W-1:0] LAST_OFF = {OFF_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [OFF_W-1:0]    init_cnt_r;
  logic [OFF_W-1:0]    init_cnt_next_s;

  logic                req_ready_r;
  logic                init_busy_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_rdata_r;

  logic [BANK_BITS-1:0] bank_s;
  logic [OFF_W-1:0]     off_s;
  logic                 accept_s;
  logic                 rd_s;

  logic [OFF_W-1:0]     wr_off_s;
  logic [DATA_W-1:0]    wr_data_s;
  logic [NBANK-1:0]     bank_we_s;
  logic [DATA_W-1:0]    rd_word_s [NBANK];

  assign bank_s   = req_addr[ADDR_W-1 -: BANK_BITS];
  assign off_s    = req_addr[OFF_W-1:0];
  // req_ready_r is high exactly when the FSM is in RUN, so acceptance
  // follows the visible handshake. Reset overrides a simultaneous request.
  assign accept_s = req_valid && req_ready_r && !rst;
  assign rd_s     = accept_s && !req_we;

  // Next-state logic: INIT counts through every offset, then RUN holds until reset
  always_comb begin
    state_next_s    = state_r;
    init_cnt_next_s = init_cnt_r;
    case (state_r)
      ST_INIT: begin
        init_cnt_next_s = init_cnt_r + OFF_W'(1'b1);
        if (init_cnt_r == LAST_OFF) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN: begin
        state_next_s = ST_RUN;
      end
      default: begin
        state_next_s    = ST_INIT;
        init_cnt_next_s = {OFF_W{1'b0}};
      end
    endcase
  end

  // Write-port steering: the sweep writes every bank at once; RUN writes only the addressed bank
  always_comb begin
    wr_off_s  = off_s;
    wr_data_s = req_wdata;
    bank_we_s = {NBANK{1'b0}};
    if (rst) begin
      bank_we_s = {NBANK{1'b0}};
    end else if (state_r == ST_INIT) begin
      wr_off_s  = init_cnt_r;
      wr_data_s = INIT_VAL;
      bank_we_s = {NBANK{1'b1}};
    end else if (accept_s && req_we) begin
      bank_we_s[bank_s] = 1'b1;
    end else begin
      bank_we_s = {NBANK{1'b0}};
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Bank storage: contents are never reset, only overwritten by the sweep
    always_ff @(posedge clk) begin
      if (bank_we_s[b]) begin
        mem_r[wr_off_s] <= wr_data_s;
      end
    end

    assign rd_word_s[b] = mem_r[off_s];
  end

  // Control and response registers: all outputs are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= {OFF_W{1'b0}};
      req_ready_r <= 1'b0;
      init_busy_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      init_cnt_r  <= init_cnt_next_s;
      req_ready_r <= (state_next_s == ST_RUN);
      init_busy_r <= (state_next_s == ST_INIT);
      rsp_valid_r <= rd_s;
      if (rd_s) begin
        rsp_rdata_r <= rd_word_s[bank_s];
      end
    end
  end

  assign req_ready = req_ready_r;
  assign init_busy = init_busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_banked_ram.sv
module tb_banked_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance (8-bit data, 4 banks x 256 words)
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        init_busy;

  // Wide variant (16-bit data, 8 banks x 512 words)
  logic        rst2;
  logic        req_valid2;
  logic        req_ready2;
  logic        req_we2;
  logic [11:0] req_addr2;
  logic [15:0] req_wdata2;
  logic        rsp_valid2;
  logic [15:0] rsp_rdata2;
  logic        init_busy2;

  banked_ram dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_busy(init_busy)
  );

  banked_ram #(.DATA_W(16), .ADDR_W(12), .BANK_BITS(3), .INIT_VAL(16'hDEAD)) dut16 (
    .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .init_busy(init_busy2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flat 1024-word memory, cleared on reset, and a
  // countdown of the init cycles still remaining.
  logic [7:0] m_mem [1024];
  int         m_left = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_live  <= 1'b1;
      m_left  <= 256;
      m_valid <= 1'b0;
      m_rdata <= 8'h00;
      for (int i = 0; i < 1024; i++) m_mem[i] <= 8'h00;
    end else if (m_live) begin
      if (m_left > 0) m_left <= m_left - 1;
      if (req_valid && m_left == 0) begin
        if (req_we) begin
          m_mem[req_addr] <= req_wdata;
          m_valid <= 1'b0;
        end else begin
          m_valid <= 1'b1;
          m_rdata <= m_mem[req_addr];
        end
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare all outputs every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_left == 0});
      chk("init_busy", {31'd0, init_busy}, {31'd0, m_left != 0});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, m_rdata});
      if (rsp_valid) pulse_cnt++;
    end
  end

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_addr = 10'h000; req_wdata = 8'h00;
  endtask

  task automatic issue(input logic we, input logic [9:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk); #2;
    idle();
  endtask

  task automatic read_chk(input string name, input logic [9:0] a, input logic [7:0] exp);
    issue(1'b0, a, 8'h00);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk(name, {24'd0, rsp_rdata}, {24'd0, exp});
    @(posedge clk); #2;
  endtask

  // Count negedges with init_busy high until it drops (bounded)
  task automatic wait_init(input int start, output int cnt);
    cnt = start;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (init_busy) cnt++;
      else break;
    end
    @(posedge clk); #2;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic idle2();
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 12'h000; req_wdata2 = 16'h0000;
  endtask

  task automatic op16(input logic we, input logic [11:0] a, input logic [15:0] d);
    req_valid2 = 1'b1; req_we2 = we; req_addr2 = a; req_wdata2 = d;
    @(posedge clk); #2;
    idle2();
  endtask

  task automatic read16_chk(input string name, input logic [11:0] a, input logic [15:0] exp);
    op16(1'b0, a, 16'h0000);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, rsp_valid2}, 32'd1);
    chk(name, {16'd0, rsp_rdata2}, {16'd0, exp});
    @(posedge clk); #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; rst2 = 1'b1;
    idle(); idle2();
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;

    // 1: init length and cleared contents
    wait_init(0, cnt);
    chk("init_len", cnt, 32'd256);
    read_chk("rd000", 10'h000, 8'h00);
    read_chk("rd0ff", 10'h0FF, 8'h00);
    read_chk("rd100", 10'h100, 8'h00);
    read_chk("rd3ff", 10'h3FF, 8'h00);

    // 2: bank isolation
    issue(1'b1, 10'h005, 8'h11);
    issue(1'b1, 10'h105, 8'h22);
    issue(1'b1, 10'h205, 8'h33);
    issue(1'b1, 10'h305, 8'h44);
    read_chk("bank0", 10'h005, 8'h11);
    read_chk("bank1", 10'h105, 8'h22);
    read_chk("bank2", 10'h205, 8'h33);
    read_chk("bank3", 10'h305, 8'h44);
    read_chk("rd006", 10'h006, 8'h00);

    // 3: write then read next cycle, then ten back-to-back reads
    issue(1'b1, 10'h2AB, 8'hA5);
    issue(1'b0, 10'h2AB, 8'h00);
    @(negedge clk);
    chk("wr_rd_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rd_data", {24'd0, rsp_rdata}, 32'h000000A5);
    @(posedge clk); #2;
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) issue(1'b0, 10'h300 + 10'(i), 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("burst_pulses", pulse_cnt, 32'd10);

    // 4: write held from reset release is taken only once ready
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h010; req_wdata = 8'hFF;
    @(posedge clk); #2;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (req_ready) break;
      cnt++;
    end
    chk("held_init_len", cnt, 32'd256);
    @(posedge clk); #2;
    idle();
    read_chk("held_wr", 10'h010, 8'hFF);
    read_chk("cleared005", 10'h005, 8'h00);

    // 5: reset on the read-accept cycle, then reset mid-init
    issue(1'b1, 10'h123, 8'h5A);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h123;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_cancel", {31'd0, rsp_valid}, 32'd0);
    wait_init(1, cnt);
    chk("init_len2", cnt, 32'd256);
    read_chk("rst_clr", 10'h123, 8'h00);
    pulse_rst();
    repeat (50) @(posedge clk);
    #2;
    pulse_rst();
    wait_init(0, cnt);
    chk("init_restart", cnt, 32'd256);

    // 6: wide variant
    rst2 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (init_busy2) cnt++;
      else break;
    end
    chk("w_init_len", cnt, 32'd512);
    @(posedge clk); #2;
    read16_chk("w_unwr", 12'h000, 16'hDEAD);
    op16(1'b1, 12'hE01, 16'h1234);
    read16_chk("w_e01", 12'hE01, 16'h1234);
    read16_chk("w_601", 12'h601, 16'hDEAD);
    read16_chk("w_e00", 12'hE00, 16'hDEAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
